// File: rtl/sysbus_mem_responder_if.sv
// Main-bus request/response channel between an initiator and a memory target.
// Signals:
//   reqcyc  - request or write-data beat valid
//   req     - request address, or write data beat
//   reqtag  - request tag ([12] read/write, [11:8] target type)
//   respcyc - response beat valid
//   resp    - response data
//   resptag - tag echoed with every response beat
//   respack - initiator accepts the current response beat
// Modports: master (initiator side), slave (target side).
interface sysbus_mem_responder_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 13
);
    logic              reqcyc;
    logic [DATA_W-1:0] req;
    logic [TAG_W-1:0]  reqtag;
    logic              respcyc;
    logic [DATA_W-1:0] resp;
    logic [TAG_W-1:0]  resptag;
    logic              respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Main-bus memory target: serves whole 64-byte lines as 8 x 64-bit beats.
// Reads answer after LATENCY idle cycles, each beat held until respack.
// Writes absorb 8 data beats (reqcyc=0 stalls). One transaction at a time.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - slave side of the request/response channel
//   busy       - high whenever a transaction is in progress
//   err        - sticky out-of-range flag (cleared by reset only)
// Optional build macro MEMRESP_RANGECHK_EN: addresses with bits set above
// the line-index field return all-ones on read, drop write data and set err.
// Without it those bits are ignored (aliasing) and err stays 0.
module sysbus_mem_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter logic [3:0]  MEM_TYPE       = 4'h1,
    parameter int unsigned DEPTH_LINES    = 1024,
    parameter int unsigned LATENCY        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    sysbus_mem_responder_if.slave  bus,
    output logic                   busy,
    output logic                   err
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_LINES);
    localparam int unsigned ADDR_HI  = 6 + IDX_W;
    localparam int unsigned CNT_W    = $clog2(LATENCY + 1);
    localparam int unsigned MEM_W    = IDX_W + 3;
    localparam int unsigned RW_BIT   = BUS_TAG_WIDTH - 1;
    localparam int unsigned TYPE_LSB = BUS_TAG_WIDTH - 5;

    typedef enum logic [1:0] {IDLE, DELAY, RESP, WDATA} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                beat_q, beat_d;
    logic [CNT_W-1:0]          dly_q, dly_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                      oor_q, oor_d;
    logic                      respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;
    logic                      busy_q;
    logic                      err_q, err_d;

    logic                      oor_c;
    logic                      wr_en_c;
    logic [2:0]                rd_beat_c;
    logic [BUS_DATA_WIDTH-1:0] rd_word_c;

    logic [BUS_DATA_WIDTH-1:0] mem [DEPTH_LINES*8];

`ifdef MEMRESP_RANGECHK_EN
    assign oor_c = |bus.req[BUS_DATA_WIDTH-1:ADDR_HI];
`else
    assign oor_c = 1'b0;
`endif

    // Word presented next cycle: the following beat when the current one is acked.
    assign rd_beat_c = (state_q == RESP && bus.respack) ? beat_q + 3'd1 : beat_q;
    assign rd_word_c = oor_q ? '1 : mem[MEM_W'({idx_q, rd_beat_c})];

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        dly_d     = dly_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        oor_d     = oor_q;
        err_d     = err_q;
        respcyc_d = 1'b0;
        resp_d    = '0;
        resptag_d = '0;
        wr_en_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.reqcyc && bus.reqtag[TYPE_LSB +: 4] == MEM_TYPE) begin
                    idx_d   = bus.req[ADDR_HI-1:6];
                    tag_d   = bus.reqtag;
                    oor_d   = oor_c;
                    err_d   = err_q | oor_c;
                    beat_d  = '0;
                    dly_d   = '0;
                    state_d = bus.reqtag[RW_BIT] ? DELAY : WDATA;
                end
            end
            DELAY: begin
                if (dly_q == CNT_W'(LATENCY - 1)) begin
                    dly_d     = '0;
                    state_d   = RESP;
                    respcyc_d = 1'b1;
                end else begin
                    dly_d = dly_q + CNT_W'(1);
                end
            end
            RESP: begin
                respcyc_d = 1'b1;
                if (bus.respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d   = IDLE;
                        respcyc_d = 1'b0;
                    end
                end
            end
            WDATA: begin
                if (bus.reqcyc) begin
                    wr_en_c = !oor_q;
                    beat_d  = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Response data and tag are forced to zero whenever no beat is valid.
        if (respcyc_d) begin
            resp_d    = rd_word_c;
            resptag_d = tag_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            dly_q     <= '0;
            idx_q     <= '0;
            tag_q     <= '0;
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            dly_q     <= dly_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
            oor_q     <= oor_d;
            err_q     <= err_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    // Line storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_c && !reset) begin
            mem[MEM_W'({idx_q, beat_q})] <= bus.req;
        end
    end

    assign bus.respcyc = respcyc_q;
    assign bus.resp    = resp_q;
    assign bus.resptag = resptag_q;
    assign busy        = busy_q;
    assign err         = err_q;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: a word-level memory model
// predicts every read beat; a negedge monitor checks each visible beat and
// the zeroed idle outputs, while directed sequences check latency, stalls,
// ignored requests, reset abort and the out-of-range behaviour.
module tb_sysbus_mem_responder;
    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic err;

    int errors = 0;
    int checks = 0;

    logic [63:0] model_mem [int];
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];
    logic [12:0] exp_tag = 13'h1100;

    sysbus_mem_responder_if #(.DATA_W(64), .TAG_W(13)) bus ();

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH (13),
        .MEM_TYPE      (4'h1),
        .DEPTH_LINES   (DEPTH),
        .LATENCY       (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [63:0] a);
`ifdef MEMRESP_RANGECHK_EN
        return (a >> 16) != 64'h0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int line_of(input logic [63:0] a);
        return int'((a >> 6) & 64'(DEPTH - 1));
    endfunction

    function automatic logic [63:0] model_word(input logic [63:0] a, input int w);
        if (out_of_range(a)) return 64'hFFFF_FFFF_FFFF_FFFF;
        return model_mem[line_of(a) * 8 + w];
    endfunction

    // Beat monitor: every visible beat must equal the head of the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.respcyc === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %h expected no beat", bus.resp);
                end else begin
                    check("beat_data", bus.resp, exp_q[0]);
                    check("beat_tag", 64'(bus.resptag), 64'(exp_tag));
                    if (bus.respack === 1'b1) begin
                        got_q.push_back(bus.resp);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_resp", bus.resp, 64'h0);
                check("idle_tag", 64'(bus.resptag), 64'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [63:0] base, input bit stall);
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = 13'h0100;
        tick();
        for (int w = 0; w < 8; w++) begin
            if (stall && w == 3) begin
                bus.reqcyc = 1'b0;
                bus.req    = 64'hDEAD_BEEF;
                tick();
            end
            bus.reqcyc = 1'b1;
            bus.req    = base + 64'(w);
            tick();
            if (!out_of_range(addr)) model_mem[line_of(addr) * 8 + w] = base + 64'(w);
            if (w == 4) check("write_busy", 64'(busy), 64'h1);
        end
        bus.reqcyc = 1'b0;
        bus.req    = '0;
        @(negedge clk);
        check("write_done_busy", 64'(busy), 64'h0);
        #1;
    endtask

    task automatic read_line(input logic [63:0] addr, input logic [3:0] pat, input bit intrude);
        int lat;
        int cyc;
        got_q.delete();
        for (int w = 0; w < 8; w++) exp_q.push_back(model_word(addr, w));
        bus.reqcyc  = 1'b1;
        bus.req     = addr;
        bus.reqtag  = exp_tag;
        bus.respack = pat[0];
        tick();
        bus.reqcyc = 1'b0;
        bus.req    = '0;
        bus.reqtag = '0;
        lat = 0;
        @(negedge clk);
        check("read_busy", 64'(busy), 64'h1);
        while (bus.respcyc !== 1'b1 && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        check("read_latency", 64'(lat), 64'(LAT));
        #1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.respack = pat[cyc % 4];
            bus.reqcyc  = intrude && cyc == 2;
            bus.req     = (intrude && cyc == 2) ? 64'h2000 : 64'h0;
            bus.reqtag  = (intrude && cyc == 2) ? exp_tag : 13'h0;
            @(negedge clk);
            if (intrude && cyc == 2) check("intrude_busy", 64'(busy), 64'h1);
            #1;
        end
        check("read_remaining", 64'(exp_q.size()), 64'h0);
        check("read_beat_count", 64'(got_q.size()), 64'h8);
        @(posedge clk);
        #1;
        bus.respack = 1'b0;
        @(negedge clk);
        check("read_end_respcyc", 64'(bus.respcyc), 64'h0);
        check("read_end_busy", 64'(busy), 64'h0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.reqcyc  = 1'b0;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.respack = 1'b0;
        tick();
        @(negedge clk);
        check("rst_respcyc", 64'(bus.respcyc), 64'h0);
        check("rst_resp", bus.resp, 64'h0);
        check("rst_resptag", 64'(bus.resptag), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        tick();
        reset = 1'b0;
        tick();

        // Basic write then full-speed read.
        check("pin_line", 64'(line_of(64'h1000)), 64'd64);
        check("pin_tag", 64'(exp_tag), 64'h1100);
        write_line(64'h1000, 64'h10, 1'b0);
        read_line(64'h1000, 4'hF, 1'b0);
        check("pin_beat0", got_q[0], 64'h10);
        check("pin_beat7", got_q[7], 64'h17);

        // Mid-line address still returns the whole line from word 0.
        read_line(64'h1028, 4'hF, 1'b0);
        check("pin_midline_beat0", got_q[0], 64'h10);

        // Stalled write, then read with sparse acks.
        write_line(64'h2040, 64'h200, 1'b1);
        read_line(64'h2040, 4'b1001, 1'b0);
        check("pin_stall_beat3", got_q[3], 64'h203);

        // Request arriving during RESP is ignored.
        read_line(64'h1000, 4'hF, 1'b1);
        repeat (6) tick();

        // Request for another target type gets no response.
        bus.reqcyc = 1'b1;
        bus.req    = 64'h1000;
        bus.reqtag = 13'h1200;
        tick();
        bus.reqcyc = 1'b0;
        bus.reqtag = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("other_type_busy", 64'(busy), 64'h0);
            #1;
        end

        // Reset while beat 3 is on the bus aborts the read.
        for (int w = 0; w < 8; w++) exp_q.push_back(model_word(64'h2040, w));
        bus.reqcyc  = 1'b1;
        bus.req     = 64'h2040;
        bus.reqtag  = exp_tag;
        bus.respack = 1'b1;
        tick();
        bus.reqcyc = 1'b0;
        bus.req    = '0;
        bus.reqtag = '0;
        begin
            int lat = 0;
            @(negedge clk);
            while (bus.respcyc !== 1'b1 && lat < 50) begin
                lat++;
                @(negedge clk);
            end
            check("abort_latency", 64'(lat), 64'(LAT));
        end
        tick();
        tick();
        tick();
        reset       = 1'b1;
        bus.respack = 1'b0;
        @(negedge clk);
        check("abort_beat3_valid", 64'(bus.respcyc), 64'h1);
        check("abort_beat3_data", bus.resp, 64'h203);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_respcyc", 64'(bus.respcyc), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        exp_q.delete();
        #1;
        tick();
        read_line(64'h2040, 4'hF, 1'b0);
        check("post_abort_beat7", got_q[7], 64'h207);

        // Address above the index field.
        write_line(64'h0, 64'hA0, 1'b0);
        read_line(64'h1 << 40, 4'hF, 1'b0);
`ifdef MEMRESP_RANGECHK_EN
        check("oor_beat0", got_q[0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("oor_err", 64'(err), 64'h1);
`else
        check("alias_beat0", got_q[0], 64'hA0);
        check("alias_beat7", got_q[7], 64'hA7);
        check("alias_err", 64'(err), 64'h0);
`endif
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
- Main-bus memory target that answers line requests from bus initiators such as the page-table walker and the caches.
- Accepts one request at a time.
- For a read, returns a 64-byte line as 8 beats of 64-bit data, each held until the initiator acknowledges it.
- For a write, absorbs 8 data beats into internal storage.
- Serves as the simulation memory model behind the bus arbiter.

Parameters:
- BUS_DATA_WIDTH, 64, beat width in bits.
- BUS_TAG_WIDTH, 13, tag width; tag[12] = read (1) / write (0); tag[11:8] = target type.
- MEM_TYPE, 4'h1, tag[11:8] value that identifies memory.
- DEPTH_LINES, 1024, number of 64-byte lines stored (power of two).
- LATENCY, 4, idle cycles between read accept and first beat (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- bus_reqcyc  in  1  request/data valid.
- bus_req  in  64  request address, or write data beat.
- bus_reqtag  in  13  request tag.
- bus_respcyc  out  1  response beat valid.
- bus_resp  out  64  response data.
- bus_resptag  out  13  tag echoed with every response beat.
- bus_respack  in  1  initiator accepts the current beat.
- busy  out  1  high whenever not IDLE.
- err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset: state=IDLE; bus_respcyc=0, bus_resp=0, bus_resptag=0, busy=0, err=0; beat and delay counters 0. Storage contents are not cleared. Reset mid-transfer aborts the transfer in the next cycle, with no further beats.
- Line index = bus_req[6+log2(DEPTH_LINES)-1:6]. Bits [5:0] are ignored: every transfer covers the whole aligned line, words 0..7 in ascending order. Initiators pick their word by beat count.
- IDLE:
  - Sample when bus_reqcyc=1 and tag[11:8]==MEM_TYPE. Latch index and tag; go to DELAY if tag[12]=1, else WDATA.
  - Requests with any other type are ignored (they belong to other targets).
- DELAY: count LATENCY cycles, then enter RESP with beat=0. Request-side inputs are ignored.
- RESP:
  - Drive bus_respcyc=1, bus_resp=mem[index][beat], bus_resptag=latched tag.
  - The beat advances only on a cycle where bus_respack=1; data is held stable otherwise.
  - On ack of beat 7, return to IDLE and drop bus_respcyc next cycle.
  - Back-to-back acks give 8 beats in 8 consecutive cycles.
  - A read of a line written earlier returns the written data.
- WDATA:
  - Each cycle with bus_reqcyc=1 writes bus_req to mem[index][beat]; beat++.
  - Cycles with bus_reqcyc=0 stall the transfer.
  - After the 8th beat, return to IDLE.
  - No response is issued for writes.
- Requests arriving while busy=1 are ignored, not queued; the arbiter guarantees a single outstanding transaction.
- bus_resp, bus_resptag = 0 whenever bus_respcyc=0.
- Beat counter is 3 bits and wraps 7->0 only on transfer completion.

Optional Feature:
- Macro: MEMRESP_RANGECHK_EN.
- Defined: an address with any bit set above the index field is out of range.
  - Out-of-range read returns 8 beats of 64'hFFFF_FFFF_FFFF_FFFF and sets err.
  - Out-of-range write discards data and sets err.
  - err clears only on reset.
- Undefined: upper bits are ignored, so addresses alias modulo DEPTH_LINES lines; err is tied to 0.

Test Plan:
- Reset, then write line at addr 0x1000 with beats 0x10..0x17, then read 0x1000 with respack held high -> after LATENCY=4 cycles, 8 consecutive beats 0x10..0x17, bus_resptag=0x1100 on each beat.
- Read 0x1028 (mid-line) -> beats start at word 0 of line 0x1000; same data as above.
- Read with respack toggled 1,0,0,1,... -> each beat held until acked; the 8 beats complete with no loss or duplication.
- Second request issued during RESP -> ignored, busy stays 1, no extra response. Request with tag[11:8]=4'h2 in IDLE -> no response.
- Assert reset at beat 3 of a read -> bus_respcyc=0 the next cycle; a fresh read afterwards completes normally with the stored data.
- With MEMRESP_RANGECHK_EN, read addr 1<<40 -> 8 beats of all-ones, err=1. Without it, the same read returns line (1<<40 mod 64K bytes) and err=0.
